// File: rtl/jtag_link_pkg.sv
// rtl/jtag_link_pkg.sv - shared types and constants for the JTAG host link
package jtag_link_pkg;

    localparam int BYTE_W      = 8;
    localparam int MIN_CLK_DIV = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        TRAIL,
        GUARD
    } jtagState_t;

endpackage

// File: rtl/jtag_host_shifter_if.sv
// rtl/jtag_host_shifter_if.sv - client-side byte handshake bundle of the JTAG host
interface jtag_host_shifter_if;
    import jtag_link_pkg::*;

    logic [BYTE_W-1:0] iTX_DATA;
    logic              iTX_Valid;
    logic              oTX_Ready;
    logic [BYTE_W-1:0] oRX_DATA;
    logic              oRX_Valid;
    logic              oBusy;

    modport master (
        output iTX_DATA, iTX_Valid,
        input  oTX_Ready, oRX_DATA, oRX_Valid, oBusy
    );

    modport slave (
        input  iTX_DATA, iTX_Valid,
        output oTX_Ready, oRX_DATA, oRX_Valid, oBusy
    );
endinterface

// File: rtl/jtag_tx_fifo.sv
// rtl/jtag_tx_fifo.sv - byte FIFO feeding the shifter; a pop frees a full slot in the same cycle
module jtag_tx_fifo
    import jtag_link_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iPush,
    input  logic [BYTE_W-1:0] iData,
    input  logic              iPop,
    output logic [BYTE_W-1:0] oData,
    output logic              oFull,
    output logic              oEmpty
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [BYTE_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [PW:0]       count;
    logic              doPush;
    logic              doPop;

    assign oFull  = (count == (PW+1)'(FIFO_DEPTH));
    assign oEmpty = (count == '0);
    assign oData  = mem[rdPtr];
    assign doPop  = iPop && !oEmpty;
    assign doPush = iPush && (!oFull || doPop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge iCLK or posedge iRST_n) begin
        if (iRST_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + (PW+1)'(doPush) - (PW+1)'(doPop);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge iCLK) begin
        if (doPush) mem[wrPtr] <= iData;
    end
endmodule

// File: rtl/jtag_host_shifter.sv
// rtl/jtag_host_shifter.sv - byte-framed TCK/TCS/TDI/TDO serial master with TX FIFO
module jtag_host_shifter
    import jtag_link_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
)
(
    input  logic               iCLK,
    input  logic               iRST_n,
    jtag_host_shifter_if.slave bus,
    output logic               TCK,
    output logic               TCS,
    output logic               TDI,
    input  logic               TDO
);
    // Dividers below the minimum would let the synchronizer sample TDO outside the high phase
    localparam int         DIV     = (CLK_DIV < MIN_CLK_DIV) ? MIN_CLK_DIV : CLK_DIV;
    localparam logic [7:0] PH_LAST = 8'(DIV - 1);

    jtagState_t        state;
    logic [7:0]        phase;
    logic [2:0]        bitCnt;
    logic [6:0]        txShift;
    logic [6:0]        rxShift;
    logic              lastByte;
    logic              tdoMeta;
    logic              tdoSync;
    logic [BYTE_W-1:0] rxData;
    logic              rxValid;

    logic              phaseDone;
    logic              popReq;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [BYTE_W-1:0] fifoData;

    assign phaseDone = (phase == PH_LAST);
    assign popReq    = !fifoEmpty &&
                       ((state == IDLE) ||
                        (state == HIGH && phaseDone && bitCnt == 3'd7));

    jtag_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) uFifo (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iPush  (bus.iTX_Valid),
        .iData  (bus.iTX_DATA),
        .iPop   (popReq),
        .oData  (fifoData),
        .oFull  (fifoFull),
        .oEmpty (fifoEmpty)
    );

    // Ready also covers the full-but-popping cycle, so a handshake always means acceptance
    assign bus.oTX_Ready = !fifoFull || popReq;
    assign bus.oBusy     = !TCS || !fifoEmpty;
    assign bus.oRX_DATA  = rxData;
    assign bus.oRX_Valid = rxValid;

    // Two-flop synchronizer for the asynchronous TDO line
    always_ff @(posedge iCLK or posedge iRST_n) begin
        if (iRST_n) begin
            tdoMeta <= 1'b0;
            tdoSync <= 1'b0;
        end else begin
            tdoMeta <= TDO;
            tdoSync <= tdoMeta;
        end
    end

    // Frame FSM: phase timing, TCK/TCS/TDI generation, TDO capture at each falling edge
    always_ff @(posedge iCLK or posedge iRST_n) begin
        if (iRST_n) begin
            state    <= IDLE;
            phase    <= '0;
            bitCnt   <= '0;
            txShift  <= '0;
            rxShift  <= '0;
            lastByte <= 1'b0;
            TCK      <= 1'b0;
            TCS      <= 1'b1;
            TDI      <= 1'b0;
            rxData   <= '0;
            rxValid  <= 1'b0;
        end else begin
            rxValid <= 1'b0;
            phase   <= phaseDone ? 8'd0 : phase + 8'd1;
            case (state)
                IDLE: begin
                    phase <= '0;
                    TCK   <= 1'b0;
                    TCS   <= 1'b1;
                    if (!fifoEmpty) begin
                        txShift  <= fifoData[7:1];
                        TDI      <= fifoData[0];
                        bitCnt   <= '0;
                        lastByte <= 1'b0;
                        TCS      <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (phaseDone) begin
                        TCK   <= 1'b1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (phaseDone) begin
                        TCK     <= 1'b0;
                        state   <= LOW;
                        rxShift <= {tdoSync, rxShift[6:1]};
                        if (bitCnt != 3'd7) begin
                            bitCnt  <= bitCnt + 3'd1;
                            TDI     <= txShift[0];
                            txShift <= {1'b0, txShift[6:1]};
                        end else begin
                            rxData  <= {tdoSync, rxShift};
                            rxValid <= 1'b1;
                            bitCnt  <= '0;
                            if (!fifoEmpty) begin
                                txShift <= fifoData[7:1];
                                TDI     <= fifoData[0];
                            end else begin
                                lastByte <= 1'b1;
                            end
                        end
                    end
                end
                LOW: begin
                    if (phaseDone) begin
                        if (lastByte) begin
                            state <= TRAIL;
                        end else begin
                            TCK   <= 1'b1;
                            state <= HIGH;
                        end
                    end
                end
                TRAIL: begin
                    if (phaseDone) begin
                        TCS   <= 1'b1;
                        state <= GUARD;
                    end
                end
                GUARD: begin
                    if (phaseDone) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_host_shifter.sv
// tb/tb_jtag_host_shifter.sv - self-checking bench for jtag_host_shifter
module tb_jtag_host_shifter;
    localparam int DIV = 4;

    typedef struct {
        logic [7:0] data;
        logic [7:0] expRx;
    } vec_t;

    logic iCLK = 1'b0;
    logic iRST_n;
    always #5 iCLK = ~iCLK;

    jtag_host_shifter_if bus4 ();
    jtag_host_shifter_if bus3 ();

    logic tck4, tcs4, tdi4;
    logic tdo4    = 1'b0;
    logic prevBit = 1'b0;
    logic tck3, tcs3, tdi3;
    logic tdo3;
    assign tdo3 = 1'b1;

    jtag_host_shifter #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut4 (
        .iCLK(iCLK), .iRST_n(iRST_n), .bus(bus4),
        .TCK(tck4), .TCS(tcs4), .TDI(tdi4), .TDO(tdo4)
    );

    jtag_host_shifter #(.CLK_DIV(3), .FIFO_DEPTH(4)) dut3 (
        .iCLK(iCLK), .iRST_n(iRST_n), .bus(bus3),
        .TCK(tck3), .TCS(tcs3), .TDI(tdi3), .TDO(tdo3)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic       tdiBits[$];
    int         frameLens[$];
    int         gapLens[$];
    int         lowRun = 0;
    int         highRun = 0;
    logic [7:0] rxQ[$];
    int         rxCyc[$];
    int         tdiHighChg = 0;
    logic       tdiLast = 1'b0;

    always @(posedge iCLK) cyc <= cyc + 1;

    always @(posedge tck4) tdiBits.push_back(tdi4);

    // Far-end device: one-TCK register delay from TDI to TDO, cleared while TCS is high
    always @(posedge tck4 or posedge tcs4) begin
        if (tcs4) begin
            prevBit <= 1'b0;
            tdo4    <= 1'b0;
        end else begin
            tdo4    <= prevBit;
            prevBit <= tdi4;
        end
    end

    // Wire monitors sampled on the falling iCLK edge
    always @(negedge iCLK) begin
        if (tcs4 === 1'b0) begin
            if (highRun > 0) gapLens.push_back(highRun);
            highRun <= 0;
            lowRun  <= lowRun + 1;
        end else begin
            if (lowRun > 0) frameLens.push_back(lowRun);
            lowRun  <= 0;
            highRun <= highRun + 1;
        end
        if (bus4.oRX_Valid === 1'b1) begin
            rxQ.push_back(bus4.oRX_DATA);
            rxCyc.push_back(cyc);
        end
        if (tck4 === 1'b1 && tdi4 !== tdiLast) tdiHighChg <= tdiHighChg + 1;
        tdiLast <= tdi4;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Received bit n is the sent bit n-1 of the same frame; the first one is the cleared register
    function automatic logic [7:0] rxModel(input logic [7:0] sent[$], input int idx);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) begin
            int n = idx * 8 + j;
            r[j] = (n == 0) ? 1'b0 : sent[(n - 1) / 8][(n - 1) % 8];
        end
        return r;
    endfunction

    task automatic writeBurst(input logic [7:0] data[$], output logic [7:0] acc[$], output int refused);
        acc = {};
        refused = 0;
        foreach (data[i]) begin
            @(negedge iCLK);
            bus4.iTX_Valid = 1'b1;
            bus4.iTX_DATA  = data[i];
            if (bus4.oTX_Ready === 1'b1) acc.push_back(data[i]);
            else refused++;
        end
        @(negedge iCLK);
        bus4.iTX_Valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge iCLK);
        while (!(tcs4 === 1'b1 && bus4.oBusy === 1'b0) && n < 4000) begin
            @(negedge iCLK);
            n++;
        end
        chk("idle_wait", 32'(n < 4000), 1);
        repeat (3 * DIV) @(negedge iCLK);
    endtask

    task automatic checkFrame(input logic [7:0] sent[$], input int f0, input int b0, input int r0, input string tag);
        int k = sent.size();
        chk({tag, "_frames"}, frameLens.size() - f0, 1);
        if (frameLens.size() > f0) chk({tag, "_tcs_low"}, frameLens[f0], DIV * (2 + 16 * k));
        chk({tag, "_tck_rises"}, tdiBits.size() - b0, 8 * k);
        chk({tag, "_rx_count"}, rxQ.size() - r0, k);
        for (int i = 0; i < k; i++) begin
            logic [7:0] t;
            if (tdiBits.size() >= b0 + 8 * (i + 1)) begin
                for (int j = 0; j < 8; j++) t[j] = tdiBits[b0 + 8 * i + j];
                chk({tag, "_tdi_byte"}, t, sent[i]);
            end
            if (rxQ.size() > r0 + i) chk({tag, "_rx_byte"}, rxQ[r0 + i], rxModel(sent, i));
            if (i > 0 && rxCyc.size() > r0 + i)
                chk({tag, "_rx_spacing"}, rxCyc[r0 + i] - rxCyc[r0 + i - 1], 16 * DIV);
        end
    endtask

    initial begin
        vec_t       vecs[5];
        logic [7:0] data[$];
        logic [7:0] acc[$];
        logic [7:0] whole[$];
        int         refused, f0, b0, r0, g0, n;

        vecs[0] = '{8'hA5, 8'h4A};
        vecs[1] = '{8'h3C, 8'h78};
        vecs[2] = '{8'hFF, 8'hFE};
        vecs[3] = '{8'h01, 8'h02};
        vecs[4] = '{8'h80, 8'h00};

        iRST_n = 1'b1;
        bus4.iTX_Valid = 1'b0; bus4.iTX_DATA = '0;
        bus3.iTX_Valid = 1'b0; bus3.iTX_DATA = '0;
        repeat (3) @(negedge iCLK);
        chk("rst_tck", tck4, 0);
        chk("rst_tcs", tcs4, 1);
        chk("rst_tdi", tdi4, 0);
        chk("rst_rx_data", bus4.oRX_DATA, 0);
        chk("rst_rx_valid", bus4.oRX_Valid, 0);
        chk("rst_busy", bus4.oBusy, 0);
        chk("rst_tx_ready", bus4.oTX_Ready, 1);
        @(negedge iCLK);
        iRST_n = 1'b0;
        repeat (4 * DIV) @(negedge iCLK);

        // Write-to-TCS latency and single 0xA5 frame
        f0 = frameLens.size(); b0 = tdiBits.size(); r0 = rxQ.size();
        @(negedge iCLK);
        bus4.iTX_Valid = 1'b1; bus4.iTX_DATA = 8'hA5;
        @(negedge iCLK);
        bus4.iTX_Valid = 1'b0;
        n = 1;
        while (tcs4 === 1'b1 && n < 20) begin
            @(negedge iCLK);
            n++;
        end
        chk("tcs_fall_latency", n, 2);
        waitIdle();
        data = {}; data.push_back(8'hA5);
        checkFrame(data, f0, b0, r0, "single_a5");

        // Table of single-byte frames through the loopback responder
        for (int i = 0; i < 5; i++) begin
            f0 = frameLens.size(); b0 = tdiBits.size(); r0 = rxQ.size();
            data = {}; data.push_back(vecs[i].data);
            writeBurst(data, acc, refused);
            waitIdle();
            if (rxQ.size() == r0 + 1) chk("vec_rx", rxQ[r0], vecs[i].expRx);
            else chk("vec_rx_count", rxQ.size() - r0, 1);
            checkFrame(acc, f0, b0, r0, "vec");
        end

        // Two-byte burst 0x3C, 0xFF in one frame
        f0 = frameLens.size(); b0 = tdiBits.size(); r0 = rxQ.size();
        data = {}; data.push_back(8'h3C); data.push_back(8'hFF);
        writeBurst(data, acc, refused);
        waitIdle();
        chk("burst2_accepted", acc.size(), 2);
        checkFrame(acc, f0, b0, r0, "burst2");

        // Write landing in TRAIL starts a new frame after GUARD
        f0 = frameLens.size(); b0 = tdiBits.size(); r0 = rxQ.size();
        data = {}; data.push_back(8'h81);
        writeBurst(data, acc, refused);
        n = 0;
        while (tcs4 === 1'b1 && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        n = 1;
        while (n < 69) begin
            @(negedge iCLK);
            n++;
        end
        g0 = gapLens.size();
        chk("trail_still_low", tcs4, 0);
        bus4.iTX_Valid = 1'b1; bus4.iTX_DATA = 8'h42;
        @(negedge iCLK);
        bus4.iTX_Valid = 1'b0;
        waitIdle();
        chk("trail_frames", frameLens.size() - f0, 2);
        if (frameLens.size() >= f0 + 2) begin
            chk("trail_len0", frameLens[f0], DIV * 18);
            chk("trail_len1", frameLens[f0 + 1], DIV * 18);
        end
        chk("guard_gap_count", gapLens.size() - g0, 1);
        if (gapLens.size() > g0) chk("guard_gap", gapLens[g0], DIV + 1);
        chk("trail_rx_count", rxQ.size() - r0, 2);
        if (rxQ.size() >= r0 + 2) begin
            chk("trail_rx0", rxQ[r0], 8'h02);
            chk("trail_rx1", rxQ[r0 + 1], 8'h84);
        end

        // Randomized bursts of 1..5 bytes from idle, each forming a single frame
        for (int it = 0; it < 6; it++) begin
            int k = $urandom_range(1, 5);
            f0 = frameLens.size(); b0 = tdiBits.size(); r0 = rxQ.size();
            data = {};
            for (int i = 0; i < k; i++) data.push_back(8'($urandom));
            writeBurst(data, acc, refused);
            chk("rand_refused", refused, 0);
            waitIdle();
            checkFrame(acc, f0, b0, r0, "rand");
        end

        // Fill the FIFO while a frame runs: fifth write is dropped, rest sent in order
        f0 = frameLens.size(); b0 = tdiBits.size(); r0 = rxQ.size();
        data = {}; data.push_back(8'hE7);
        writeBurst(data, whole, refused);
        n = 0;
        while (tcs4 === 1'b1 && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        data = {};
        for (int i = 0; i < 5; i++) data.push_back(8'(8'h10 + 8'(i * 17)));
        writeBurst(data, acc, refused);
        chk("full_accepted", acc.size(), 4);
        chk("full_refused", refused, 1);
        chk("full_ready_low", bus4.oTX_Ready, 0);
        foreach (acc[i]) whole.push_back(acc[i]);
        waitIdle();
        checkFrame(whole, f0, b0, r0, "full");

        // Reset during bit 3 of a two-byte burst
        b0 = tdiBits.size();
        data = {}; data.push_back(8'h96); data.push_back(8'h11);
        writeBurst(data, acc, refused);
        n = 0;
        while (tdiBits.size() < b0 + 4 && n < 500) begin
            @(negedge iCLK);
            n++;
        end
        chk("bit3_reached", 32'(n < 500), 1);
        @(negedge iCLK);
        chk("pre_reset_tck", tck4, 1);
        r0 = rxQ.size();
        #2 iRST_n = 1'b1;
        #1;
        chk("async_rst_tcs", tcs4, 1);
        chk("async_rst_tck", tck4, 0);
        repeat (3) @(negedge iCLK);
        iRST_n = 1'b0;
        repeat (30) @(negedge iCLK);
        chk("rst_no_rx", rxQ.size() - r0, 0);
        chk("rst_fifo_empty", bus4.oBusy, 0);
        chk("rst_tcs_idle", tcs4, 1);
        f0 = frameLens.size(); b0 = tdiBits.size(); r0 = rxQ.size();
        data = {}; data.push_back(8'h5A);
        writeBurst(data, acc, refused);
        waitIdle();
        checkFrame(acc, f0, b0, r0, "post_rst");

        // CLK_DIV=3 instance with TDO held high
        @(negedge iCLK);
        bus3.iTX_Valid = 1'b1; bus3.iTX_DATA = 8'h5A;
        @(negedge iCLK);
        bus3.iTX_Valid = 1'b0;
        n = 0;
        while (bus3.oRX_Valid !== 1'b1 && n < 600) begin
            @(negedge iCLK);
            n++;
        end
        chk("div3_rx_seen", 32'(n < 600), 1);
        chk("div3_rx_data", bus3.oRX_DATA, 8'hFF);

        chk("tdi_stable_while_tck_high", tdiHighChg, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jtag_host_shifter.md
# jtag_host_shifter

Host-side serial master for the byte-oriented TCK/TCS/TDI/TDO link that our FPGA-side JTAG UART bridge terminates. It accepts bytes from a local client, buffers them in a small FIFO, and frames them on the wire. It generates TCK from iCLK, shifts TDI LSB-first and captures TDO into received bytes. It is used as the bus-functional initiator in loopback benches and as a bit-bang host in multi-FPGA builds.

## Interface
Parameters:
- CLK_DIV, 4, iCLK cycles per TCK half-period; legal range 3..255.
- FIFO_DEPTH, 4, TX byte FIFO entries; power of two, 2..16.

Ports:
- iCLK  in  1  system clock.
- iRST_n  in  1  reset, asynchronous, active-high (despite the name).
- iTX_DATA  in  8  byte to send.
- iTX_Valid  in  1  write strobe; accepted when oTX_Ready=1.
- oTX_Ready  out  1  FIFO not full.
- oRX_DATA  out  8  byte captured from TDO; held until the next capture.
- oRX_Valid  out  1  one-cycle pulse, oRX_DATA valid.
- oBusy  out  1  high while TCS is low, or while the FIFO is non-empty.
- TCK  out  1  serial clock, idles low.
- TCS  out  1  frame select, active-low; high resets the far-end bit counters.
- TDI  out  1  serial data to the device.
- TDO  in  1  serial data from the device; asynchronous to iCLK.

## Operation
- Reset values: TCK=0, TCS=1, TDI=0, oRX_DATA=0, oRX_Valid=0, oBusy=0, oTX_Ready=1. Reset also empties the FIFO and puts the FSM in IDLE.
- FIFO write: a write occurs when iTX_Valid=1 and oTX_Ready=1. A write while full is dropped, with no corruption.
- FSM states:
  - IDLE: TCS=1, TCK=0. If the FIFO is non-empty, pop one byte into the shift register and go to SETUP.
  - SETUP: TCS=0, TCK=0, TDI=bit0. Lasts CLK_DIV cycles, then go to HIGH.
  - HIGH: TCK=1 for CLK_DIV cycles, then go to LOW.
  - LOW: TCK=0 for CLK_DIV cycles.
    - On entry to LOW (the TCK falling edge), capture the synchronized TDO into rx[bitcnt].
    - If bitcnt<7: increment bitcnt and drive TDI = next bit.
    - If bitcnt=7 and the FIFO is non-empty: pop the next byte, set TDI = its bit0, bitcnt=0. The frame continues.
    - At the end of LOW: go to HIGH, unless the byte completed with the FIFO empty, in which case go to TRAIL.
  - TRAIL: TCS=0, TCK=0 for CLK_DIV cycles, then go to GUARD.
  - GUARD: TCS=1 for CLK_DIV cycles, then go to IDLE. This guarantees the minimum TCS-high time.
- Byte completion: oRX_Valid pulses the cycle after the 8th falling-edge capture, with oRX_DATA = the full 8-bit rx.
- TDO path: 2-flop synchronizer. With CLK_DIV>=3, the sampled value reflects TDO from inside the high phase.
- Bit order: LSB first in both directions. Received bit i is TDO as driven by the device after rising edge i.
- Counters:
  - Phase counter: 8 bits, wraps at CLK_DIV-1.
  - bitcnt: 3 bits.
- Simultaneous events:
  - A FIFO write in the same cycle as a pop is legal when the FIFO is full; it is accepted, since the pop frees the slot in the same cycle.
  - A write landing during TRAIL does not reopen the frame. It is sent in a new frame after GUARD.
- Reset mid-frame: TCS returns to 1 and TCK to 0 immediately (asynchronously). The partial byte is discarded, and no oRX_Valid is produced.

## Timing
- Write to TCS falling (FIFO empty, IDLE): 2 cycles (write, then pop).
- TCS low duration for an N-byte burst: CLK_DIV·(2 + 16N) cycles.
- Per byte: 16·CLK_DIV cycles. There is no inter-byte gap while the FIFO stays non-empty.
- TDI changes only while TCK=0, and at least CLK_DIV cycles before each rising edge.
- oRX_Valid to the next oRX_Valid within a burst: exactly 16·CLK_DIV cycles.

## Structure
- Shared package jtag_link_pkg:
  - FSM state enum: IDLE, SETUP, HIGH, LOW, TRAIL, GUARD.
  - Byte width constant: 8.
  - Minimum CLK_DIV constant: 3.
- Sub-module jtag_tx_fifo: synchronous FIFO, FIFO_DEPTH×8, with full/empty flags and the same-cycle push/pop rule above. The FSM, shifter and TDO synchronizer live in the top module.

## Test plan
- Single byte, CLK_DIV=4, write 0xA5 → TDI at the 8 rising edges = 1,0,1,0,0,1,0,1; TCS low for 72 cycles; GUARD of 4 cycles before IDLE.
- Responder model looping TDI back to TDO with its one-TCK register delay; send 0x3C, 0xFF → oRX_Valid twice, 64 cycles apart; received values match the model's shifted stream.
- Write 5 bytes back-to-back with FIFO_DEPTH=4 → 4 or 5 accepted depending on pop timing; oTX_Ready drops exactly while full; the single frame has TCS low for 4·(2+16·k) cycles with no TCK gap.
- Write while full with no pop → byte dropped; FIFO contents are unchanged and sent in order.
- Assert reset during bit 3 of a byte → TCS=1 and TCK=0 the same cycle; no oRX_Valid; FIFO empty after release; a subsequent byte is framed correctly.
- CLK_DIV=3, TDO held constant at 1 → oRX_DATA=0xFF; the synchronizer sampling margin holds.
